// File: rtl/ray_pkg.sv
// Shared widths, limits and state encoding for the nearest-wall selector.
package ray_pkg;

   localparam int COORD_W = 13;
   localparam int DIFF_W  = 14;
   localparam int DIST_W  = 27;
   localparam int COL_W   = 9;

   localparam logic [DIST_W-1:0] DIST_MAX = 27'h7FFFFFF;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_CAPTURE = 3'd1;
   localparam logic [2:0] ST_SQ0     = 3'd2;
   localparam logic [2:0] ST_SQ1     = 3'd3;
   localparam logic [2:0] ST_SQ2     = 3'd4;
   localparam logic [2:0] ST_SQ3     = 3'd5;
   localparam logic [2:0] ST_CMP     = 3'd6;
   localparam logic [2:0] ST_OUT     = 3'd7;

   typedef enum logic [2:0] {
      S_IDLE    = ST_IDLE,
      S_CAPTURE = ST_CAPTURE,
      S_SQ0     = ST_SQ0,
      S_SQ1     = ST_SQ1,
      S_SQ2     = ST_SQ2,
      S_SQ3     = ST_SQ3,
      S_CMP     = ST_CMP,
      S_OUT     = ST_OUT
   } state_t;

   // Player-minus-wall difference; one extra bit keeps the full +/-8191 range.
   function automatic logic signed [DIFF_W-1:0] coord_diff(
      input logic signed [COORD_W-1:0] a,
      input logic signed [COORD_W-1:0] b
   );
      return {a[COORD_W-1], a} - {b[COORD_W-1], b};
   endfunction

endpackage

// File: rtl/square_unit.sv
// Combinational squarer: 14-bit signed difference in, 27-bit unsigned square out.
// Operands are limited to +/-8191, so the magnitude always fits in 13 bits.
module square_unit
   import ray_pkg::*;
(
   input  logic signed [DIFF_W-1:0] diff,
   output logic        [DIST_W-1:0] sq
);

   localparam int MAG_W  = DIFF_W - 1;
   localparam int PROD_W = 2 * MAG_W;

   logic [MAG_W-1:0]  mag;
   logic [PROD_W-1:0] prod;

   // take the magnitude first so the multiplier is a plain unsigned 13x13
   always_comb begin
      mag  = diff[DIFF_W-1] ? MAG_W'(-diff) : MAG_W'(diff);
      prod = PROD_W'(mag) * PROD_W'(mag);
      sq   = DIST_W'(prod);
   end

endmodule

// File: rtl/ray_select_nearest.sv
// Nearest-wall selector: captures the horizontal and vertical finder results
// for one ray, squares the player-to-wall distances and hands the nearer valid
// hit to the column renderer over valid/ready.
// Build option: RAY_SELECT_PAR_SQ_EN instantiates two squarers and finishes
// the squares in two cycles instead of four; results are identical.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for ray_start
// S_CAPTURE | collecting horiz/vert end_calc pulses, either order
// S_SQ0     | hdx^2 -> dist_h   (parallel build: hdx^2 + hdy^2)
// S_SQ1     | + hdy^2 -> dist_h (parallel build: vdx^2 + vdy^2 -> dist_v)
// S_SQ2     | vdx^2 -> dist_v   (unused in parallel build)
// S_SQ3     | + vdy^2 -> dist_v (unused in parallel build)
// S_CMP     | pick nearer valid hit, load result registers
// S_OUT     | raise out_valid, hold until out_ready
module ray_select_nearest
   import ray_pkg::*;
(
   input  logic                      clock,
   input  logic                      resetn,
   input  logic                      ray_start,
   input  logic        [COL_W-1:0]   column,
   input  logic signed [COORD_W-1:0] playerX,
   input  logic signed [COORD_W-1:0] playerY,
   input  logic signed [COORD_W-1:0] horiz_wallX,
   input  logic signed [COORD_W-1:0] horiz_wallY,
   input  logic                      horiz_wall_found,
   input  logic                      horiz_end_calc,
   input  logic signed [COORD_W-1:0] vert_wallX,
   input  logic signed [COORD_W-1:0] vert_wallY,
   input  logic                      vert_wall_found,
   input  logic                      vert_end_calc,
   output logic                      busy,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic signed [COORD_W-1:0] near_x,
   output logic signed [COORD_W-1:0] near_y,
   output logic        [DIST_W-1:0]  near_dist_sq,
   output logic                      near_side,
   output logic                      near_found,
   output logic        [COL_W-1:0]   out_column
);

   state_t                    state;
   logic        [COL_W-1:0]   col_q;
   logic signed [COORD_W-1:0] px_q, py_q;
   logic signed [COORD_W-1:0] hx_q, hy_q, vx_q, vy_q;
   logic                      hf_q, vf_q;
   logic                      h_cap, v_cap;
   logic        [DIST_W-1:0]  dist_h, dist_v;

   logic signed [DIFF_W-1:0]  hdx, hdy, vdx, vdy;

   assign hdx  = coord_diff(px_q, hx_q);
   assign hdy  = coord_diff(py_q, hy_q);
   assign vdx  = coord_diff(px_q, vx_q);
   assign vdy  = coord_diff(py_q, vy_q);
   assign busy = (state != S_IDLE);

`ifdef RAY_SELECT_PAR_SQ_EN
   logic signed [DIFF_W-1:0] sq0_in, sq1_in;
   logic        [DIST_W-1:0] sq0_out, sq1_out;

   // S_SQ0 squares the horizontal pair, S_SQ1 the vertical pair
   always_comb begin
      sq0_in = hdx;
      sq1_in = hdy;
      if (state == S_SQ1) begin
         sq0_in = vdx;
         sq1_in = vdy;
      end
   end

   square_unit u_sq0 (.diff(sq0_in), .sq(sq0_out));
   square_unit u_sq1 (.diff(sq1_in), .sq(sq1_out));
`else
   logic signed [DIFF_W-1:0] sq_in;
   logic        [DIST_W-1:0] sq_out;

   // one operand per square state on the shared squarer
   always_comb begin
      case (state)
         S_SQ1:   sq_in = hdy;
         S_SQ2:   sq_in = vdx;
         S_SQ3:   sq_in = vdy;
         default: sq_in = hdx;
      endcase
   end

   square_unit u_sq (.diff(sq_in), .sq(sq_out));
`endif

   // sequencing, capture, accumulation and the registered result
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state        <= S_IDLE;
         col_q        <= '0;
         px_q         <= '0;
         py_q         <= '0;
         hx_q         <= '0;
         hy_q         <= '0;
         vx_q         <= '0;
         vy_q         <= '0;
         hf_q         <= 1'b0;
         vf_q         <= 1'b0;
         h_cap        <= 1'b0;
         v_cap        <= 1'b0;
         dist_h       <= '0;
         dist_v       <= '0;
         out_valid    <= 1'b0;
         near_x       <= '0;
         near_y       <= '0;
         near_dist_sq <= '0;
         near_side    <= 1'b0;
         near_found   <= 1'b0;
         out_column   <= '0;
      end else if (ray_start) begin
         // a new ray always wins; anything in flight is dropped
         col_q     <= column;
         px_q      <= playerX;
         py_q      <= playerY;
         h_cap     <= 1'b0;
         v_cap     <= 1'b0;
         out_valid <= 1'b0;
         state     <= S_CAPTURE;
      end else begin
         case (state)
            S_CAPTURE: begin
               if (horiz_end_calc) begin
                  hx_q  <= horiz_wallX;
                  hy_q  <= horiz_wallY;
                  hf_q  <= horiz_wall_found;
                  h_cap <= 1'b1;
               end
               if (vert_end_calc) begin
                  vx_q  <= vert_wallX;
                  vy_q  <= vert_wallY;
                  vf_q  <= vert_wall_found;
                  v_cap <= 1'b1;
               end
               if ((h_cap || horiz_end_calc) && (v_cap || vert_end_calc))
                  state <= S_SQ0;
            end
`ifdef RAY_SELECT_PAR_SQ_EN
            S_SQ0: begin
               dist_h <= sq0_out + sq1_out;
               state  <= S_SQ1;
            end
            S_SQ1: begin
               dist_v <= sq0_out + sq1_out;
               state  <= S_CMP;
            end
`else
            S_SQ0: begin
               dist_h <= sq_out;
               state  <= S_SQ1;
            end
            S_SQ1: begin
               dist_h <= dist_h + sq_out;
               state  <= S_SQ2;
            end
            S_SQ2: begin
               dist_v <= sq_out;
               state  <= S_SQ3;
            end
            S_SQ3: begin
               dist_v <= dist_v + sq_out;
               state  <= S_CMP;
            end
`endif
            S_CMP: begin
               // ties go to the horizontal hit
               out_column <= col_q;
               near_found <= hf_q | vf_q;
               if (hf_q && (!vf_q || dist_h <= dist_v)) begin
                  near_x       <= hx_q;
                  near_y       <= hy_q;
                  near_dist_sq <= dist_h;
                  near_side    <= 1'b0;
               end else if (vf_q) begin
                  near_x       <= vx_q;
                  near_y       <= vy_q;
                  near_dist_sq <= dist_v;
                  near_side    <= 1'b1;
               end else begin
                  near_x       <= '0;
                  near_y       <= '0;
                  near_dist_sq <= DIST_MAX;
                  near_side    <= 1'b0;
               end
               state <= S_OUT;
            end
            S_OUT: begin
               // result registers settled at the compare edge; valid follows
               if (!out_valid) begin
                  out_valid <= 1'b1;
               end else if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
